// File: rtl/riscv_pkg.sv
// RV32I constants shared by the fetch front end and the immediate extender.
// Also holds the opcode-to-immediate-format decode used at the fetch queue head.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    EXT_I = 3'd0,
    EXT_S = 3'd1,
    EXT_B = 3'd2,
    EXT_J = 3'd3,
    EXT_U = 3'd4
  } ext_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic ext_sel_e imm_sel(input logic [6:0] opc);
    case (opc)
      OPC_STORE:          return EXT_S;
      OPC_BRANCH:         return EXT_B;
      OPC_JAL:            return EXT_J;
      OPC_LUI, OPC_AUIPC: return EXT_U;
      default:            return EXT_I;
    endcase
  endfunction

  // R-type carries no immediate but is still a base opcode, so it is legal.
  function automatic logic opc_illegal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered-output synchronous FIFO with flush and occupancy count.
// Storage is reset to zero so the head reads 0 out of reset.
module sync_fifo #(
  parameter  int W  = 32,
  parameter  int D  = 2,
  localparam int AW = $clog2(D),
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop, w_full, w_empty;

  assign w_full  = (r_cnt == CW'(D));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = i_pop & ~w_empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_wdata;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/instr_fetch_queue.sv
// RV32I fetch front end: PC, credit-limited imem requests, in-order instruction
// queue with PC shadow, redirect flush with drop counting of stale responses.
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [24:0]     dec_imm_field,
  output logic [2:0]      dec_imm_sel,
  output logic            dec_illegal
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outst, r_drop;

  logic            w_pop, w_credit, w_issue, w_rsp_live;
  logic [CW-1:0]   w_q_cnt, w_sh_cnt;
  logic [XLEN-1:0] w_sh_pc;
  fetch_entry_t    w_head, w_q_wdata;

  assign dec_valid = (w_q_cnt != '0);
  // A redirect flushes the head, so a same-cycle handshake consumes nothing.
  assign w_pop     = dec_valid & dec_ready & ~redirect_valid;

  // outstanding + occupancy never exceeds DEPTH and pop <= occupancy: no underflow.
  assign w_credit = ({1'b0, r_outst} + {1'b0, w_q_cnt} - (CW+1)'(w_pop)) < (CW+1)'(DEPTH);
  assign w_issue  = rst_n & ~redirect_valid & w_credit;

  assign w_rsp_live = imem_rsp_valid & ~redirect_valid & (r_drop == '0);

  assign imem_req_valid = w_issue;
  assign imem_req_addr  = r_pc;

  // Shadow holds PCs of live outstanding requests only; stale responses never pop it.
  sync_fifo #(.W(XLEN), .D(DEPTH)) u_pc_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_issue),
    .i_wdata (r_pc),
    .i_pop   (w_rsp_live),
    .o_rdata (w_sh_pc),
    .o_count (w_sh_cnt)
  );

  assign w_q_wdata = '{instr: imem_rsp_data, pc: w_sh_pc};

  sync_fifo #(.W($bits(fetch_entry_t)), .D(DEPTH)) u_iq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_rsp_live),
    .i_wdata (w_q_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_q_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_outst <= '0;
      r_drop  <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_issue) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_pc   <= redirect_pc & ~32'h3;
        r_drop <= r_outst - CW'(imem_rsp_valid);
      end else begin
        if (w_issue) r_pc <= r_pc + 32'd4;
        if (imem_rsp_valid && r_drop != '0) r_drop <= r_drop - CW'(1);
      end
    end
  end

  assign dec_instr     = w_head.instr;
  assign dec_pc        = w_head.pc;
  assign dec_imm_field = w_head.instr[31:7];
  assign dec_imm_sel   = imm_sel(w_head.instr[6:0]);
  assign dec_illegal   = opc_illegal(w_head.instr[6:0]);

`ifndef SYNTHESIS
  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_outst != '0));
  a_shadow_underrun: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp_live |-> (w_sh_cnt != '0));
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based reference.
module tb_instr_fetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr, dec_pc;
  logic [24:0] dec_imm_field;
  logic [2:0]  dec_imm_sel;
  logic        dec_illegal;

  instr_fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_imm_field(dec_imm_field), .dec_imm_sel(dec_imm_sel),
    .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit drop; int rdy; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  req_t        oq[$];   // requests the memory still owes, oldest first
  ent_t        dq[$];   // instructions decode should see, oldest first
  logic [31:0] m_pc;
  int          cyc;
  int          checks = 0, failures = 0;
  int          lat_min = 1, lat_max = 1, rsp_pct = 100;
  bit          hold_rsp = 1'b0;

  logic        s_rv, s_dv, s_ill;
  logic [31:0] s_ra, s_dpc, s_di;
  logic [2:0]  s_sel;
  logic [24:0] s_fld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // {illegal, sel} straight from the opcode table
  function automatic logic [3:0] ref_dec(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 4'h0;
      7'h23:                             return 4'h1;
      7'h63:                             return 4'h2;
      7'h6F:                             return 4'h3;
      7'h37, 7'h17:                      return 4'h4;
      7'h33:                             return 4'h0;
      default:                           return 4'h8;
    endcase
  endfunction

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  opc;
    case (a)
      32'h400: return 32'hFE0007E3;
      32'h404: return 32'h0000006F;
      32'h408: return 32'h12345037;
      32'h40C: return 32'h00A12023;
      32'h410: return 32'hFFFFFFFF;
      default: ;
    endcase
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 13);
    case (h[3:0])
      4'd0: opc = 7'h13;  4'd1: opc = 7'h03;  4'd2: opc = 7'h67;
      4'd3: opc = 7'h73;  4'd4: opc = 7'h0F;  4'd5: opc = 7'h23;
      4'd6: opc = 7'h63;  4'd7: opc = 7'h6F;  4'd8: opc = 7'h37;
      4'd9: opc = 7'h17;  4'd10: opc = 7'h33;
      default: opc = {h[5:4], 5'b01011};
    endcase
    return {h[31:7], opc};
  endfunction

  task automatic do_cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          rsp, exp_v, pop, exp_req;
    logic [31:0] rdata;
    logic [3:0]  d;
    req_t        r;
    @(negedge clk);
    rsp = 1'b0;
    if (!hold_rsp && oq.size() > 0 && oq[0].rdy <= cyc && $urandom_range(99) < rsp_pct) rsp = 1'b1;
    rdata = rsp ? imem_word(oq[0].addr) : $urandom;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    redirect_valid = redir;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    #1;
    s_rv = imem_req_valid; s_ra = imem_req_addr; s_dv = dec_valid;
    s_dpc = dec_pc; s_di = dec_instr; s_sel = dec_imm_sel; s_ill = dec_illegal;
    s_fld = dec_imm_field;

    exp_v   = (dq.size() != 0);
    pop     = exp_v && rdy;
    exp_req = !redir && (oq.size() + dq.size() - int'(pop) < DEPTH);
    chk("dec_valid", 32'(s_dv), 32'(exp_v));
    if (exp_v) begin
      d = ref_dec(dq[0].instr);
      chk("dec_instr", s_di, dq[0].instr);
      chk("dec_pc", s_dpc, dq[0].pc);
      chk("dec_imm_field", 32'(s_fld), dq[0].instr >> 7);
      chk("dec_imm_sel", 32'(s_sel), 32'(d[2:0]));
      chk("dec_illegal", 32'(s_ill), 32'(d[3]));
    end
    chk("req_valid", 32'(s_rv), 32'(exp_req));
    if (exp_req) chk("req_addr", s_ra, m_pc);

    if (rsp) begin
      r = oq.pop_front();
      if (!redir && !r.drop) dq.push_back('{instr: rdata, pc: r.addr});
    end
    if (redir) begin
      foreach (oq[i]) oq[i].drop = 1'b1;
      dq.delete();
      m_pc = rpc & ~32'h3;
    end else begin
      if (pop) void'(dq.pop_front());
      if (exp_req) begin
        oq.push_back('{addr: m_pc, drop: 1'b0, rdy: cyc + $urandom_range(lat_max, lat_min)});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b0;
    oq.delete(); dq.delete();
    m_pc = RPC; cyc = 0; hold_rsp = 1'b0;
    #1;
    chk("rst req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst req_addr", imem_req_addr, RPC);
    chk("rst dec_valid", 32'(dec_valid), 32'd0);
    chk("rst dec_instr", dec_instr, 32'd0);
    chk("rst dec_pc", dec_pc, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          nreq, hits;
    bit          found;
    logic [31:0] dl[$];
    logic [31:0] first_req, ra[$];
    logic [31:0] tw [5] = '{32'hFE0007E3, 32'h0000006F, 32'h12345037, 32'h00A12023, 32'hFFFFFFFF};
    logic [31:0] tf [5] = '{32'h1FC000F, 32'h0, 32'h2468A0, 32'h14240, 32'h1FFFFFF};
    logic [31:0] ts [5] = '{32'd2, 32'd3, 32'd4, 32'd1, 32'd0};
    logic [31:0] ti [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};

    // streaming from reset with 1-cycle memory
    do_reset();
    do_cycle(0, 0, 1); chk("p1 req0", s_ra, 32'h100); chk("p1 dv0", 32'(s_dv), 0);
    do_cycle(0, 0, 1); chk("p1 req1", s_ra, 32'h104);
    do_cycle(0, 0, 1); chk("p1 dv2", 32'(s_dv), 1); chk("p1 dpc2", s_dpc, 32'h100);
    chk("p1 req2", s_ra, 32'h108);
    do_cycle(0, 0, 1); chk("p1 dpc3", s_dpc, 32'h104); chk("p1 rv3", 32'(s_rv), 1);

    // decode stalled for 10 cycles, then released
    do_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      do_cycle(0, 0, 0);
      if (s_rv) nreq++;
      if (i >= 2) chk("p2 held dpc", s_dpc, 32'h100);
    end
    chk("p2 reqs while stalled", nreq, 2);
    found = 0; first_req = '0;
    for (int i = 0; i < 20; i++) begin
      do_cycle(0, 0, 1);
      if (s_dv) dl.push_back(s_dpc);
      if (s_rv && !found) begin found = 1; first_req = s_ra; end
    end
    chk("p2 drained", 32'(dl.size() >= 2), 1);
    if (dl.size() >= 2) begin
      chk("p2 drain0", dl[0], 32'h100);
      chk("p2 drain1", dl[1], 32'h104);
    end
    chk("p2 resume addr", first_req, 32'h108);

    // redirect with one queued and one outstanding
    do_reset();
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    hold_rsp = 1;
    do_cycle(0, 0, 0);
    do_cycle(1, 32'h203, 0); chk("p3 queued before", 32'(s_dv), 1);
    hold_rsp = 0;
    do_cycle(0, 0, 1); chk("p3 req after", 32'(s_rv), 1); chk("p3 addr after", s_ra, 32'h200);
    chk("p3 flushed", 32'(s_dv), 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle(0, 0, 1);
      if (s_dv) begin found = 1; chk("p3 first dpc", s_dpc, 32'h200); end
    end
    chk("p3 delivered", 32'(found), 1);

    // redirect coinciding with a response and a decode handshake
    do_reset();
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    do_cycle(1, 32'h300, 1); chk("p4 head present", 32'(s_dv), 1);
    do_cycle(0, 0, 1); chk("p4 no stale", 32'(s_dv), 0); chk("p4 addr", s_ra, 32'h300);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle(0, 0, 1);
      if (s_dv) begin found = 1; chk("p4 first dpc", s_dpc, 32'h300); end
    end
    chk("p4 delivered", 32'(found), 1);

    // immediate-format decode of known words
    do_cycle(1, 32'h400, 1);
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      do_cycle(0, 0, 1);
      if (s_dv && s_dpc >= 32'h400 && s_dpc < 32'h414) begin
        int k;
        k = int'((s_dpc - 32'h400) >> 2);
        hits++;
        chk("p5 instr", s_di, tw[k]);
        chk("p5 sel", 32'(s_sel), ts[k]);
        chk("p5 illegal", 32'(s_ill), ti[k]);
        chk("p5 field", 32'(s_fld), tf[k]);
      end
    end
    chk("p5 hits", hits, 5);

    // PC wrap
    do_cycle(1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 10; i++) begin
      do_cycle(0, 0, 1);
      if (s_rv) ra.push_back(s_ra);
    end
    chk("p6 count", 32'(ra.size() >= 3), 1);
    if (ra.size() >= 3) begin
      chk("p6 req0", ra[0], 32'hFFFF_FFF8);
      chk("p6 req1", ra[1], 32'hFFFF_FFFC);
      chk("p6 req2", ra[2], 32'h0000_0000);
    end

    // randomized traffic, with a reset in the middle
    lat_min = 1; lat_max = 3; rsp_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      bit redir;
      if (i == 1500) do_reset();
      redir = ($urandom_range(99) < 3);
      do_cycle(redir, $urandom, ($urandom_range(99) < 75));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
